kv_line_fetch_arbiter: RTL and testbench



---
 rtl/kv_line_fetch_arbiter.sv | 177 +++++++++++++++++
 tb/tb_kv_line_fetch_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kv_line_fetch_arbiter.sv
// Round-robin arbiter sharing one line-fetch memory port among REQ_NUM cache refill requesters.
// Optional WAIT-state timeout with stale-beat drain is enabled by defining KV_ARB_TIMEOUT_EN.
module kv_line_fetch_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_SIZE      = 4,
    parameter int REQ_NUM        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_req_addr [REQ_NUM],
    input  logic [REQ_NUM-1:0]    i_req_valid,
    output logic [REQ_NUM-1:0]    o_req_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data [LINE_SIZE],
    output logic [REQ_NUM-1:0]    o_rsp_valid,
    input  logic [REQ_NUM-1:0]    i_rsp_ready,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_valid,
    input  logic                  i_mem_ready,
    input  logic [DATA_WIDTH-1:0] i_mem_data [LINE_SIZE],
    input  logic                  i_mem_valid,
    output logic                  o_mem_ready
);

    localparam int                PTR_W     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam logic [PTR_W:0]    REQ_NUM_W = (PTR_W+1)'(REQ_NUM);
    localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(REQ_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [PTR_W-1:0]      rr_ptr_r;
    logic [PTR_W-1:0]      grant_r;
    logic [PTR_W-1:0]      win_idx_s;
    logic [PTR_W:0]        cand_s;
    logic                  win_s;
    logic                  grant_ok_s;
    logic                  rsp_done_s;
    logic                  stale_s;
    logic                  timeout_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] line_r [LINE_SIZE];

    // Round-robin scan of request valids starting at the pointer, wrapping modulo REQ_NUM.
    always_comb begin
        win_s     = 1'b0;
        win_idx_s = '0;
        cand_s    = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            cand_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(i);
            if (cand_s >= REQ_NUM_W) begin
                cand_s = cand_s - REQ_NUM_W;
            end else begin
                cand_s = cand_s;
            end
            if (!win_s && i_req_valid[cand_s[PTR_W-1:0]]) begin
                win_s     = 1'b1;
                win_idx_s = cand_s[PTR_W-1:0];
            end else begin
                win_s     = win_s;
            end
        end
    end

    assign grant_ok_s = win_s && (state_r == ST_IDLE) && !stale_s;
    assign rsp_done_s = (state_r == ST_RESP) && i_rsp_ready[grant_r];

    // Accept pulse is the only combinational output: it follows the scan in IDLE.
    always_comb begin
        o_req_ready = '0;
        if (grant_ok_s) begin
            o_req_ready[win_idx_s] = 1'b1;
        end else begin
            o_req_ready = '0;
        end
    end

    // Next-state decode for the single-outstanding transaction sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: state_nxt_s = grant_ok_s ? ST_REQ : ST_IDLE;
            ST_REQ:  state_nxt_s = i_mem_ready ? ST_WAIT : ST_REQ;
            ST_WAIT: state_nxt_s = (i_mem_valid || timeout_s) ? ST_RESP : ST_WAIT;
            ST_RESP: state_nxt_s = rsp_done_s ? ST_IDLE : ST_RESP;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, grant, address and line registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
            grant_r  <= '0;
            addr_r   <= '0;
            for (int k = 0; k < LINE_SIZE; k++) line_r[k] <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_ok_s) begin
                grant_r <= win_idx_s;
                addr_r  <= i_req_addr[win_idx_s];
            end
            if ((state_r == ST_WAIT) && i_mem_valid) begin
                line_r <= i_mem_data;
            end else if (timeout_s) begin
                for (int k = 0; k < LINE_SIZE; k++) line_r[k] <= '0;
            end
            if (rsp_done_s) begin
                rr_ptr_r <= (grant_r == LAST_IDX) ? '0 : grant_r + PTR_W'(1);
            end
        end
    end

`ifdef KV_ARB_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TO_W-1:0] to_cnt_r;
    logic            stale_r;
    logic            err_r;

    // Timeout fires on the WAIT cycle in which the count would reach the limit without data.
    assign timeout_s = (state_r == ST_WAIT) && !i_mem_valid && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
    assign stale_s   = stale_r;
    assign o_rsp_err = err_r;

    // Timeout counter, error flag and stale-beat drain tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            to_cnt_r <= '0;
            stale_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            if ((state_r == ST_REQ) && i_mem_ready) begin
                to_cnt_r <= '0;
            end else if ((state_r == ST_WAIT) && !i_mem_valid && !timeout_s) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end
            if (timeout_s) begin
                stale_r <= 1'b1;
                err_r   <= 1'b1;
            end else begin
                if (stale_r && i_mem_valid) stale_r <= 1'b0;
                if (rsp_done_s) err_r <= 1'b0;
            end
        end
    end
`else
    assign timeout_s = 1'b0;
    assign stale_s   = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    // Remaining outputs are decoded from state or driven straight from registers.
    always_comb begin
        o_rsp_valid = '0;
        if (state_r == ST_RESP) begin
            o_rsp_valid[grant_r] = 1'b1;
        end else begin
            o_rsp_valid = '0;
        end
    end

    assign o_rsp_data  = line_r;
    assign o_mem_addr  = addr_r;
    assign o_mem_valid = (state_r == ST_REQ);
    assign o_mem_ready = (state_r == ST_WAIT) || stale_s;

endmodule

// File: tb/tb_kv_line_fetch_arbiter.sv
// Self-checking bench for kv_line_fetch_arbiter: vector table plus hand-written reset/spurious/timeout sequences.
module tb_kv_line_fetch_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LS = 4;
    localparam int RN = 2;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [AW-1:0] i_req_addr [RN];
    logic [RN-1:0] i_req_valid;
    logic [RN-1:0] o_req_ready;
    logic [DW-1:0] o_rsp_data [LS];
    logic [RN-1:0] o_rsp_valid;
    logic [RN-1:0] i_rsp_ready;
    logic          o_rsp_err;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_valid;
    logic          i_mem_ready;
    logic [DW-1:0] i_mem_data [LS];
    logic          i_mem_valid;
    logic          o_mem_ready;

    kv_line_fetch_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_SIZE(LS), .REQ_NUM(RN), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_addr(i_req_addr), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_err(o_rsp_err),
        .o_mem_addr(o_mem_addr), .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
        .i_mem_data(i_mem_data), .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] seed;
        int          mem_wait;
        int          data_wait;
        int          rsp_wait;
        bit          spur;
        int          exp_grant;
        logic [1:0]  exp_ready;
    } vec_t;

    typedef struct {
        int          grant;
        logic [31:0] addr;
        logic [31:0] seed;
    } sb_t;

    sb_t  sb_q [$];
    vec_t vecs [9];
    vec_t hv;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_line(input logic [31:0] seed);
        for (int k = 0; k < LS; k++) i_mem_data[k] = seed + 32'(k);
    endtask

    // One full transaction; memory data word k is seed+k.
    task automatic run_txn(input vec_t v);
        sb_t        e;
        sb_t        got;
        logic [1:0] oh;
        @(negedge i_clk);
        i_req_addr[0] = v.addr0;
        i_req_addr[1] = v.addr1;
        i_req_valid   = v.valid;
        i_mem_ready   = 1'b0;
        i_rsp_ready   = 2'b00;
        i_mem_valid   = v.spur;
        set_line(32'hDEAD0000);
        #1;
        chk("accept", 64'(o_req_ready), 64'(v.exp_ready));
        chk("idle_mem_ready", 64'(o_mem_ready), 64'd0);
        oh      = 2'b01 << v.exp_grant;
        e.grant = v.exp_grant;
        e.addr  = (v.exp_grant == 1) ? v.addr1 : v.addr0;
        e.seed  = v.seed;
        sb_q.push_back(e);
        got     = e;
        for (int w = 0; w <= v.mem_wait; w++) begin
            @(negedge i_clk);
            i_req_valid = v.valid & ~oh;
            i_mem_ready = (w == v.mem_wait);
            i_mem_valid = v.spur;
            #1;
            chk("req_mem_valid", 64'(o_mem_valid), 64'd1);
            chk("req_mem_addr", 64'(o_mem_addr), 64'(e.addr));
            chk("busy_no_accept", 64'(o_req_ready), 64'd0);
            chk("req_mem_ready", 64'(o_mem_ready), 64'd0);
        end
        for (int w = 0; w <= v.data_wait; w++) begin
            @(negedge i_clk);
            i_mem_ready = 1'b0;
            i_mem_valid = (w == v.data_wait);
            if (w == v.data_wait) set_line(v.seed);
            else set_line(32'hBAD00000);
            #1;
            chk("wait_mem_ready", 64'(o_mem_ready), 64'd1);
            chk("wait_mem_valid", 64'(o_mem_valid), 64'd0);
            chk("wait_no_rsp", 64'(o_rsp_valid), 64'd0);
        end
        for (int w = 0; w <= v.rsp_wait; w++) begin
            @(negedge i_clk);
            i_mem_valid = 1'b0;
            set_line(32'h0);
            i_rsp_ready = (w == v.rsp_wait) ? oh : ~oh;
            #1;
            if (w == 0) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty: got no entry expected one");
                end else begin
                    got = sb_q.pop_front();
                end
            end
            chk("rsp_valid", 64'(o_rsp_valid), 64'(2'b01 << got.grant));
            chk("rsp_err", 64'(o_rsp_err), 64'd0);
            for (int k = 0; k < LS; k++) chk("rsp_data", 64'(o_rsp_data[k]), 64'(got.seed + 32'(k)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        valid  addr0         addr1         seed          mw dw rw spur grant ready
        vecs[0] = '{2'b01, 32'h0000_0100, 32'h0000_0200, 32'h0000_0001, 0, 0, 0, 1'b0, 0, 2'b01};
        vecs[1] = '{2'b10, 32'h0000_0110, 32'h0000_0210, 32'h0000_0011, 0, 0, 0, 1'b0, 1, 2'b10};
        vecs[2] = '{2'b11, 32'h0000_0120, 32'h0000_0220, 32'h0000_0021, 0, 1, 0, 1'b0, 0, 2'b01};
        vecs[3] = '{2'b11, 32'h0000_0130, 32'h0000_0230, 32'h0000_0031, 0, 0, 1, 1'b0, 1, 2'b10};
        vecs[4] = '{2'b11, 32'h0000_0140, 32'h0000_0240, 32'h0000_0041, 1, 0, 0, 1'b0, 0, 2'b01};
        vecs[5] = '{2'b11, 32'h0000_0150, 32'h0000_0250, 32'h0000_0051, 0, 0, 0, 1'b0, 1, 2'b10};
        vecs[6] = '{2'b10, 32'h0000_0160, 32'h0000_0260, 32'h0000_0061, 5, 0, 3, 1'b0, 1, 2'b10};
        vecs[7] = '{2'b11, 32'h0000_0170, 32'h0000_0270, 32'h0000_0071, 2, 2, 0, 1'b1, 0, 2'b01};
        vecs[8] = '{2'b01, 32'h0000_0180, 32'h0000_0280, 32'h0000_0081, 0, 0, 0, 1'b0, 0, 2'b01};

        i_rst       = 1'b1;
        i_req_valid = 2'b00;
        i_rsp_ready = 2'b00;
        i_mem_ready = 1'b0;
        i_mem_valid = 1'b0;
        i_req_addr[0] = 32'h0;
        i_req_addr[1] = 32'h0;
        set_line(32'h0);
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_req_ready", 64'(o_req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(o_rsp_err), 64'd0);
        chk("rst_rsp_data", 64'(o_rsp_data[0]), 64'd0);
        chk("rst_mem_valid", 64'(o_mem_valid), 64'd0);
        chk("rst_mem_addr", 64'(o_mem_addr), 64'd0);
        chk("rst_mem_ready", 64'(o_mem_ready), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int n = 0; n < 9; n++) run_txn(vecs[n]);

        // Spurious beats while idle with no requesters.
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            i_req_valid = 2'b00;
            i_rsp_ready = 2'b00;
            i_mem_valid = (c < 2);
            set_line(32'h5555_0000);
            #1;
            chk("spur_mem_ready", 64'(o_mem_ready), 64'd0);
            chk("spur_rsp_valid", 64'(o_rsp_valid), 64'd0);
            chk("spur_mem_valid", 64'(o_mem_valid), 64'd0);
        end

        // Reset in WAIT with req1 pending; pointer is 1 before the reset.
        @(negedge i_clk);
        i_mem_valid   = 1'b0;
        i_req_addr[0] = 32'h0000_0400;
        i_req_valid   = 2'b01;
        #1;
        chk("rw_accept", 64'(o_req_ready), 64'h1);
        @(negedge i_clk);
        i_req_valid = 2'b10;
        i_mem_ready = 1'b1;
        #1;
        chk("rw_mem_valid", 64'(o_mem_valid), 64'd1);
        @(negedge i_clk);
        i_mem_ready = 1'b0;
        #1;
        chk("rw_in_wait", 64'(o_mem_ready), 64'd1);
        @(negedge i_clk);
        i_rst       = 1'b1;
        i_req_valid = 2'b00;
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("rw_req_ready", 64'(o_req_ready), 64'd0);
        chk("rw_mem_valid0", 64'(o_mem_valid), 64'd0);
        chk("rw_mem_ready0", 64'(o_mem_ready), 64'd0);
        chk("rw_rsp_valid0", 64'(o_rsp_valid), 64'd0);
        chk("rw_mem_addr0", 64'(o_mem_addr), 64'd0);
        chk("rw_rsp_data0", 64'(o_rsp_data[0]), 64'd0);
        chk("rw_rsp_err0", 64'(o_rsp_err), 64'd0);
        hv = '{2'b11, 32'h0000_0500, 32'h0000_0600, 32'h0000_0A01, 0, 0, 0, 1'b0, 0, 2'b01};
        run_txn(hv);
        hv = '{2'b10, 32'h0000_0510, 32'h0000_0610, 32'h0000_0B01, 0, 0, 0, 1'b0, 1, 2'b10};
        run_txn(hv);

`ifdef KV_ARB_TIMEOUT_EN
        // No data: error response after 8 WAIT cycles, then stall until the late beat drains.
        @(negedge i_clk);
        i_rsp_ready   = 2'b00;
        i_req_addr[0] = 32'h0000_0700;
        i_req_valid   = 2'b01;
        #1;
        chk("to_accept", 64'(o_req_ready), 64'h1);
        @(negedge i_clk);
        i_req_valid = 2'b00;
        i_mem_ready = 1'b1;
        #1;
        chk("to_mem_valid", 64'(o_mem_valid), 64'd1);
        for (int w = 0; w < 8; w++) begin
            @(negedge i_clk);
            i_mem_ready = 1'b0;
            #1;
            chk("to_wait_ready", 64'(o_mem_ready), 64'd1);
            chk("to_wait_no_rsp", 64'(o_rsp_valid), 64'd0);
        end
        @(negedge i_clk);
        i_rsp_ready = 2'b01;
        #1;
        chk("to_rsp_valid", 64'(o_rsp_valid), 64'h1);
        chk("to_rsp_err", 64'(o_rsp_err), 64'd1);
        for (int k = 0; k < LS; k++) chk("to_rsp_data", 64'(o_rsp_data[k]), 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            i_rsp_ready = 2'b00;
            i_req_valid = 2'b01;
            i_mem_valid = (c == 3);
            set_line(32'hBEEF_0000);
            #1;
            chk("stale_no_accept", 64'(o_req_ready), 64'd0);
            chk("stale_mem_ready", 64'(o_mem_ready), 64'd1);
            chk("stale_mem_valid", 64'(o_mem_valid), 64'd0);
        end
        hv = '{2'b01, 32'h0000_0800, 32'h0000_0900, 32'h0000_0C01, 0, 1, 0, 1'b0, 0, 2'b01};
        run_txn(hv);
`else
        // Without the timeout feature WAIT holds indefinitely.
        hv = '{2'b01, 32'h0000_0800, 32'h0000_0900, 32'h0000_0C01, 0, 20, 0, 1'b0, 0, 2'b01};
        run_txn(hv);
`endif

        @(negedge i_clk);
        i_req_valid = 2'b00;
        i_rsp_ready = 2'b00;
        #1;
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
